// File: rtl/present_pkg.sv
// present_pkg: shared constants, FSM state type and PRESENT-80 helper functions.
// Used by the decryption core, its interface and its inverse S-box layer.
package present_pkg;

    localparam int KEY_W   = 80;
    localparam int BLOCK_W = 64;

    typedef enum logic [1:0] {IDLE, KEYGEN, DECRYPT, DONE} present_state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Forward permutation sends bit i to 16*i mod 63, so the inverse gathers from there.
    function automatic logic [BLOCK_W-1:0] p_layer_inv(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        for (int i = 0; i < BLOCK_W - 1; i++) o[i] = s[(16 * i) % 63];
        o[BLOCK_W-1] = s[BLOCK_W-1];
        return o;
    endfunction

    function automatic logic [KEY_W-1:0] key_rot_fwd(input logic [KEY_W-1:0] k, input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = SBOX[t[79:76]];
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [KEY_W-1:0] key_rot_inv(input logic [KEY_W-1:0] k, input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t = k;
        t[19:15] = t[19:15] ^ rc;
        t[79:76] = INV_SBOX[t[79:76]];
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_decrypt_core_if.sv
// present_decrypt_core_if: ciphertext/key input and plaintext output handshakes.
interface present_decrypt_core_if;

    logic                          in_valid;
    logic                          in_ready;
    logic [present_pkg::BLOCK_W-1:0] data_in;
    logic [present_pkg::KEY_W-1:0]   key;
    logic                          out_valid;
    logic                          out_ready;
    logic [present_pkg::BLOCK_W-1:0] data_out;

    modport master (output in_valid, data_in, key, out_ready, input in_ready, out_valid, data_out);
    modport slave  (input in_valid, data_in, key, out_ready, output in_ready, out_valid, data_out);

endinterface

// File: rtl/present_decrypt_core_inv_substitution.sv
// inv_substitution: 16 parallel 4-bit PRESENT inverse S-boxes over a 64-bit block.
module inv_substitution
    import present_pkg::*;
(
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o
);

    for (genvar i = 0; i < BLOCK_W / 4; i++) begin : g_sbox
        assign data_o[4*i +: 4] = INV_SBOX[data_i[4*i +: 4]];
    end

endmodule

// File: rtl/present_decrypt_core.sv
// present_decrypt_core: iterative PRESENT-80 decryption (forward key expansion, then inverse rounds).
// Optional last-round-key cache enabled by defining PRESENT_KEY_CACHE_EN.
module present_decrypt_core
    import present_pkg::*;
#(
    parameter int ROUNDS = 31
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    present_decrypt_core_if.slave       bus_io
);

    localparam int CW = $clog2(ROUNDS + 1);

    present_state_t     fsm_q;
    logic [CW-1:0]      cnt_q;
    logic [BLOCK_W-1:0] blk_q, blk_d, perm_d, data_q;
    logic [KEY_W-1:0]   key_q, key_fwd_d, key_bwd_d;
    logic               in_ready_q, out_valid_q;
    logic [4:0]         rc_d;
`ifdef PRESENT_KEY_CACHE_EN
    logic [KEY_W-1:0]   tag_q, lastkey_q;
    logic               cache_vld_q;
`endif

    assign rc_d      = 5'(cnt_q);
    assign key_fwd_d = key_rot_fwd(key_q, rc_d);
    assign key_bwd_d = key_rot_inv(key_q, rc_d);
    assign perm_d    = p_layer_inv(blk_q ^ key_q[79:16]);

    inv_substitution u_inv_sub (.data_i(perm_d), .data_o(blk_d));

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.data_out  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            blk_q       <= '0;
            key_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef PRESENT_KEY_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else begin
            case (fsm_q)
                IDLE: if (bus_io.in_valid && in_ready_q) begin
                    blk_q      <= bus_io.data_in;
                    in_ready_q <= 1'b0;
`ifdef PRESENT_KEY_CACHE_EN
                    if (cache_vld_q && bus_io.key == tag_q) begin
                        key_q <= lastkey_q;
                        cnt_q <= CW'(ROUNDS);
                        fsm_q <= DECRYPT;
                    end else begin
                        tag_q       <= bus_io.key;
                        cache_vld_q <= 1'b0;
                        key_q       <= bus_io.key;
                        cnt_q       <= CW'(1);
                        fsm_q       <= KEYGEN;
                    end
`else
                    key_q <= bus_io.key;
                    cnt_q <= CW'(1);
                    fsm_q <= KEYGEN;
`endif
                end
                KEYGEN: begin
                    key_q <= key_fwd_d;
                    cnt_q <= (cnt_q == CW'(ROUNDS)) ? cnt_q : cnt_q + CW'(1);
                    if (cnt_q == CW'(ROUNDS)) begin
                        fsm_q <= DECRYPT;
`ifdef PRESENT_KEY_CACHE_EN
                        lastkey_q   <= key_fwd_d;
                        cache_vld_q <= 1'b1;
`endif
                    end
                end
                DECRYPT: begin
                    blk_q <= blk_d;
                    key_q <= key_bwd_d;
                    cnt_q <= cnt_q - CW'(1);
                    // Last inverse round also applies the whitening key K_1.
                    if (cnt_q == CW'(1)) begin
                        data_q      <= blk_d ^ key_bwd_d[79:16];
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end
                end
                DONE: if (bus_io.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    fsm_q       <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule
